// File: rtl/rvfi_seq_pkg.sv
// Shared types and helpers for the RVFI check sequencer.
package rvfi_seq_pkg;

  // Per-channel progress: waiting for trig, waiting for check, finished.
  typedef enum logic [1:0] {
    WAIT_TRIG  = 2'd0,
    WAIT_CHECK = 2'd1,
    DONE       = 2'd2
  } chan_state_t;

  // Largest value a cw-bit counter can hold; the cycle counter saturates here.
  function automatic logic [63:0] cw_max(input int unsigned cw);
    if (cw >= 64) begin
      return {64{1'b1}};
    end
    return (64'd1 << cw) - 64'd1;
  endfunction

endpackage

// File: rtl/rvfi_seq_channel.sv
// One trig/check channel: gates raw strobes so exactly one trig, then one check, is issued.
module rvfi_seq_channel
  import rvfi_seq_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic restart,
  input  logic chk_reset,
  input  logic raw_trig,
  input  logic raw_check,
  output logic trig_c,
  output logic check_c,
  output logic done_c
);

  chan_state_t state;

  // Strobes are suppressed during checker reset and while resetn is low.
  assign trig_c  = raw_trig & (state == WAIT_TRIG) & ~chk_reset & resetn;
  assign check_c = raw_check & ~chk_reset & resetn & ((state == WAIT_CHECK) | trig_c);
  assign done_c  = (state == DONE);

  // Channel state register; restart returns to WAIT_TRIG regardless of strobes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= WAIT_TRIG;
    end else if (restart) begin
      state <= WAIT_TRIG;
    end else begin
      case (state)
        WAIT_TRIG: begin
          if (trig_c && check_c) begin
            state <= DONE;
          end else if (trig_c) begin
            state <= WAIT_CHECK;
          end
        end
        WAIT_CHECK: begin
          if (check_c) begin
            state <= DONE;
          end
        end
        DONE:    state <= DONE;
        default: state <= WAIT_TRIG;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Cycle/trig sequencer for formal check harnesses.
// Optional feature: define RVFI_SEQ_UNBOUNDED_EN to take trig/check from ext_trig/ext_check
// instead of the fixed TRIG_CYCLE/CHECK_CYCLE schedule.
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int unsigned           CW           = 8,
  parameter int unsigned           NCHAN        = 1,
  parameter int unsigned           RESET_CYCLES = 1,
  parameter logic [NCHAN*CW-1:0]   TRIG_CYCLE   = {NCHAN{8'd10}},
  parameter logic [NCHAN*CW-1:0]   CHECK_CYCLE  = {NCHAN{8'd20}}
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             restart,
  input  logic [NCHAN-1:0] ext_trig,
  input  logic [NCHAN-1:0] ext_check,
  output logic [CW-1:0]    cycle,
  output logic             chk_reset,
  output logic [NCHAN-1:0] trig,
  output logic [NCHAN-1:0] check,
  output logic             done
);

  localparam logic [CW-1:0] CYCLE_MAX = CW'(cw_max(CW));

  logic [CW-1:0]    cycle_reg;
  logic [NCHAN-1:0] chan_done;

  // Restart reads as cycle 0 in the same cycle it is asserted.
  assign cycle     = restart ? '0 : cycle_reg;
  assign chk_reset = (64'(cycle) < 64'(RESET_CYCLES));
  assign done      = &chan_done;

  // Saturating cycle counter; restart reloads 1 so the next cycle reads 1.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cycle_reg <= '0;
    end else if (restart) begin
      cycle_reg <= CW'(1);
    end else if (cycle_reg != CYCLE_MAX) begin
      cycle_reg <= cycle_reg + CW'(1);
    end
  end

`ifndef RVFI_SEQ_UNBOUNDED_EN
  // External strobes only matter in unbounded mode.
  logic unused_ext;
  assign unused_ext = ^{ext_trig, ext_check};
`endif

  for (genvar i = 0; i < int'(NCHAN); i++) begin : g_chan
    logic raw_trig;
    logic raw_check;

`ifdef RVFI_SEQ_UNBOUNDED_EN
    assign raw_trig  = ext_trig[i];
    assign raw_check = ext_check[i];
`else
    localparam logic [CW-1:0] TRIG_AT  = TRIG_CYCLE[i*CW +: CW];
    localparam logic [CW-1:0] CHECK_AT = CHECK_CYCLE[i*CW +: CW];

    // Schedules that could skip or repeat a strobe are rejected at elaboration.
    if (TRIG_AT > CHECK_AT) begin : g_err_order
      $error("rvfi_check_sequencer: channel %0d trig cycle after check cycle", i);
    end
    if (64'(CHECK_AT) >= cw_max(CW)) begin : g_err_sat
      $error("rvfi_check_sequencer: channel %0d check cycle reaches counter saturation", i);
    end
    if (64'(RESET_CYCLES) > 64'(TRIG_AT)) begin : g_err_rst
      $error("rvfi_check_sequencer: channel %0d trig cycle inside reset window", i);
    end

    assign raw_trig  = (cycle == TRIG_AT);
    assign raw_check = (cycle == CHECK_AT);
`endif

    rvfi_seq_channel u_chan (
      .clock     (clock),
      .resetn    (resetn),
      .restart   (restart),
      .chk_reset (chk_reset),
      .raw_trig  (raw_trig),
      .raw_check (raw_check),
      .trig_c    (trig[i]),
      .check_c   (check[i]),
      .done_c    (chan_done[i])
    );
  end

endmodule
